dcache_repair_arbiter: RTL and testbench

Services block-miss repair requests from the L1 data cache controller by fetching 1024-bit blocks from the next memory level over a narrow beat-based port. It picks between pending read-miss and write-miss repairs with round-robin fairness, and merges them when both target the same block. It acknowledges each granted requester, assembles the block from memory beats, and drives the one-cycle `repair_resolved` fill (address, data, full mask) back into the cache write port.

---
 rtl/dcache_repair_arbiter.sv | 156 +++++++++++++++
 tb/tb_dcache_repair_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_repair_arbiter.sv
// Block-miss repair arbiter: round-robin/merge between read and write miss
// repairs, fetches a block over a beat port and drives a one-cycle cache fill.
module dcache_repair_arbiter #(
  parameter int unsigned BLOCK_BITS  = 1024,
  parameter int unsigned BEAT_BITS   = 128,
  parameter int unsigned OFFSET_BITS = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_repair_request,
  input  logic [31:0]             missed_raddr,
  input  logic                    write_repair_request,
  input  logic [31:0]             missed_waddr,
  output logic                    read_repair_req_acq,
  output logic                    write_repair_req_acq,
  output logic                    repair_resolved,
  output logic [31:0]             fill_addr,
  output logic [BLOCK_BITS-1:0]   fill_data,
  output logic [BLOCK_BITS/8-1:0] fill_mask,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [31:0]             mem_req_addr,
  input  logic                    mem_resp_valid,
  input  logic [BEAT_BITS-1:0]    mem_resp_data,
  output logic                    busy
);

  localparam int unsigned NBEATS = BLOCK_BITS / BEAT_BITS;
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned IDX_W  = $clog2(BLOCK_BITS);
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACK     = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_FILL    = 3'd3;
  localparam logic [2:0] S_RESOLVE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             grant_rd_q, grant_rd_d;
  logic             grant_wr_q, grant_wr_d;
  logic             last_wr_q, last_wr_d;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_d;
  logic             beat_we;
  logic [31:0]      raddr_blk, waddr_blk;
  logic [IDX_W-1:0] beat_base;

  assign raddr_blk = missed_raddr & ALIGN_MASK;
  assign waddr_blk = missed_waddr & ALIGN_MASK;
  assign beat_base = IDX_W'(32'(beat_cnt) * BEAT_BITS);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, arbitration and beat bookkeeping
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    grant_rd_d = grant_rd_q;
    grant_wr_d = grant_wr_q;
    last_wr_d  = last_wr_q;
    beat_cnt_d = beat_cnt;
    beat_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read_repair_request && write_repair_request) begin
          state_d = S_ACK;
          if (raddr_blk == waddr_blk) begin
            addr_d     = raddr_blk;
            grant_rd_d = 1'b1;
            grant_wr_d = 1'b1;
          end else if (last_wr_q) begin
            addr_d     = raddr_blk;
            grant_rd_d = 1'b1;
            grant_wr_d = 1'b0;
          end else begin
            addr_d     = waddr_blk;
            grant_rd_d = 1'b0;
            grant_wr_d = 1'b1;
          end
        end else if (read_repair_request) begin
          state_d    = S_ACK;
          addr_d     = raddr_blk;
          grant_rd_d = 1'b1;
          grant_wr_d = 1'b0;
        end else if (write_repair_request) begin
          state_d    = S_ACK;
          addr_d     = waddr_blk;
          grant_rd_d = 1'b0;
          grant_wr_d = 1'b1;
        end
      end
      S_ACK: state_d = S_REQ;
      S_REQ: begin
        if (mem_req_ready) begin
          state_d    = S_FILL;
          beat_cnt_d = '0;
        end
      end
      S_FILL: begin
        if (mem_resp_valid) begin
          beat_we    = 1'b1;
          beat_cnt_d = beat_cnt + 1'b1;
          if (beat_cnt == LAST_BEAT) state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        // A merged pass counts as a read so the write side wins the next tie
        last_wr_d = (grant_rd_q && grant_wr_q) ? 1'b0 : grant_wr_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q               <= '0;
      grant_rd_q           <= 1'b0;
      grant_wr_q           <= 1'b0;
      last_wr_q            <= 1'b1;
      beat_cnt             <= '0;
      fill_data            <= '0;
      read_repair_req_acq  <= 1'b0;
      write_repair_req_acq <= 1'b0;
      mem_req_valid        <= 1'b0;
      mem_req_addr         <= '0;
      repair_resolved      <= 1'b0;
      fill_addr            <= '0;
      fill_mask            <= '0;
      busy                 <= 1'b0;
    end else begin
      addr_q               <= addr_d;
      grant_rd_q           <= grant_rd_d;
      grant_wr_q           <= grant_wr_d;
      last_wr_q            <= last_wr_d;
      beat_cnt             <= beat_cnt_d;
      if (beat_we) fill_data[beat_base +: BEAT_BITS] <= mem_resp_data;
      read_repair_req_acq  <= (state_d == S_ACK) && grant_rd_d;
      write_repair_req_acq <= (state_d == S_ACK) && grant_wr_d;
      mem_req_valid        <= (state_d == S_REQ);
      mem_req_addr         <= (state_d == S_REQ) ? addr_d : 32'd0;
      repair_resolved      <= (state_d == S_RESOLVE);
      fill_addr            <= (state_d == S_RESOLVE) ? addr_d : 32'd0;
      fill_mask            <= (state_d == S_RESOLVE) ? '1 : '0;
      busy                 <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_dcache_repair_arbiter.sv
// Directed bench for dcache_repair_arbiter: arbitration, merge, backpressure,
// beat gaps and reset during a fill, with hand-computed expectations.
module tb_dcache_repair_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_repair_request, write_repair_request;
  logic [31:0]   missed_raddr, missed_waddr;
  logic          read_repair_req_acq, write_repair_req_acq, repair_resolved;
  logic [31:0]   fill_addr, mem_req_addr;
  logic [1023:0] fill_data;
  logic [127:0]  fill_mask;
  logic          mem_req_valid, mem_req_ready, mem_resp_valid, busy;
  logic [127:0]  mem_resp_data;

  int errors = 0;
  int checks = 0;
  int rd_acq_cnt = 0, wr_acq_cnt = 0, res_cnt = 0, req_cnt = 0;
  logic [127:0]  ones = '1;
  logic [1023:0] last_block = '0;

  dcache_repair_arbiter dut (
    .clk(clk), .rst(rst),
    .read_repair_request(read_repair_request), .missed_raddr(missed_raddr),
    .write_repair_request(write_repair_request), .missed_waddr(missed_waddr),
    .read_repair_req_acq(read_repair_req_acq), .write_repair_req_acq(write_repair_req_acq),
    .repair_resolved(repair_resolved), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_mask(fill_mask), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read_repair_req_acq)  rd_acq_cnt++;
    if (write_repair_req_acq) wr_acq_cnt++;
    if (repair_resolved)      res_cnt++;
    if (mem_req_valid && mem_req_ready) req_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] blk(input logic [31:0] seed);
    logic [1023:0] b;
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      w = seed + 32'(i);
      b[i*128 +: 128] = {w, w, w, w};
    end
    return b;
  endfunction

  // Drives beats first..first+n-1 of a block; gaps insert an idle cycle before odd beats
  task automatic send_beats(input logic [31:0] seed, input int first, input int n, input bit gaps);
    logic [31:0] w;
    for (int i = first; i < first + n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        mem_resp_valid = 1'b0;
        tick();
      end
      w = seed + 32'(i);
      mem_resp_valid = 1'b1;
      mem_resp_data  = {w, w, w, w};
      tick();
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if ({read_repair_req_acq, write_repair_req_acq, repair_resolved, mem_req_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 0000", {read_repair_req_acq, write_repair_req_acq, repair_resolved, mem_req_valid}); end
    checks++; if (fill_data !== '0) begin errors++; $display("FAIL reset_fill_data: got %h want 0", fill_data); end
    checks++; if (fill_addr !== 32'd0 || fill_mask !== '0 || mem_req_addr !== 32'd0) begin
      errors++; $display("FAIL reset_addr_mask: fill_addr %h mask %h req_addr %h want 0", fill_addr, fill_mask, mem_req_addr); end
  endtask

  task automatic test_single_read();
    read_repair_request = 1'b1;
    missed_raddr = 32'h0000_12C4;
    mem_req_ready = 1'b1;
    tick();
    checks++; if (read_repair_req_acq !== 1'b1 || write_repair_req_acq !== 1'b0) begin
      errors++; $display("FAIL single_acq: rd %0b wr %0b want 1 0", read_repair_req_acq, write_repair_req_acq); end
    read_repair_request = 1'b0;
    tick();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1280) begin
      errors++; $display("FAIL single_req: valid %0b addr %h want 1 00001280", mem_req_valid, mem_req_addr); end
    tick();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL single_req_drop: got %0b want 0", mem_req_valid); end
    send_beats(32'hA000_0000, 0, 7, 1'b0);
    checks++; if (repair_resolved !== 1'b0) begin errors++; $display("FAIL single_early_resolve: got %0b want 0", repair_resolved); end
    send_beats(32'hA000_0000, 7, 1, 1'b0);
    checks++; if (repair_resolved !== 1'b1 || fill_addr !== 32'h0000_1280 || fill_mask !== ones) begin
      errors++; $display("FAIL single_resolve: res %0b addr %h mask %h want 1 00001280 all-ones", repair_resolved, fill_addr, fill_mask); end
    checks++; if (fill_data !== blk(32'hA000_0000)) begin
      errors++; $display("FAIL single_data: got %h want %h", fill_data, blk(32'hA000_0000)); end
    tick();
    checks++; if (repair_resolved !== 1'b0 || busy !== 1'b0 || fill_addr !== 32'd0 || fill_mask !== '0) begin
      errors++; $display("FAIL single_after: res %0b busy %0b addr %h mask %h want 0", repair_resolved, busy, fill_addr, fill_mask); end
    checks++; if (fill_data !== blk(32'hA000_0000)) begin errors++; $display("FAIL single_hold: got %h want %h", fill_data, blk(32'hA000_0000)); end
    last_block = blk(32'hA000_0000);
  endtask

  task automatic test_round_robin();
    int wr0;
    rst = 1'b1; tick(); rst = 1'b0;
    read_repair_request = 1'b1;  missed_raddr = 32'h0000_0100;
    write_repair_request = 1'b1; missed_waddr = 32'h0000_2000;
    wr0 = wr_acq_cnt;
    tick();
    checks++; if (read_repair_req_acq !== 1'b1 || write_repair_req_acq !== 1'b0) begin
      errors++; $display("FAIL rr_first: rd %0b wr %0b want 1 0", read_repair_req_acq, write_repair_req_acq); end
    read_repair_request = 1'b0;
    tick();
    checks++; if (mem_req_addr !== 32'h0000_0100) begin errors++; $display("FAIL rr_first_addr: got %h want 00000100", mem_req_addr); end
    tick();
    send_beats(32'hB000_0000, 0, 8, 1'b0);
    checks++; if (repair_resolved !== 1'b1 || fill_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL rr_first_resolve: res %0b addr %h want 1 00000100", repair_resolved, fill_addr); end
    checks++; if (wr_acq_cnt !== wr0) begin errors++; $display("FAIL rr_write_early: wr acqs %0d want %0d", wr_acq_cnt, wr0); end
    read_repair_request = 1'b1;
    tick(); tick();
    checks++; if (write_repair_req_acq !== 1'b1 || read_repair_req_acq !== 1'b0) begin
      errors++; $display("FAIL rr_second: rd %0b wr %0b want 0 1", read_repair_req_acq, write_repair_req_acq); end
    read_repair_request = 1'b0;
    write_repair_request = 1'b0;
    tick();
    checks++; if (mem_req_addr !== 32'h0000_2000) begin errors++; $display("FAIL rr_second_addr: got %h want 00002000", mem_req_addr); end
    tick();
    send_beats(32'hC000_0000, 0, 8, 1'b0);
    checks++; if (repair_resolved !== 1'b1 || fill_addr !== 32'h0000_2000 || fill_data !== blk(32'hC000_0000)) begin
      errors++; $display("FAIL rr_second_resolve: res %0b addr %h want 1 00002000", repair_resolved, fill_addr); end
    tick();
  endtask

  task automatic test_merge();
    int req0, res0;
    req0 = req_cnt; res0 = res_cnt;
    read_repair_request = 1'b1;  missed_raddr = 32'h0000_3004;
    write_repair_request = 1'b1; missed_waddr = 32'h0000_3040;
    tick();
    checks++; if (read_repair_req_acq !== 1'b1 || write_repair_req_acq !== 1'b1) begin
      errors++; $display("FAIL merge_acq: rd %0b wr %0b want 1 1", read_repair_req_acq, write_repair_req_acq); end
    read_repair_request = 1'b0; write_repair_request = 1'b0;
    tick();
    checks++; if (mem_req_addr !== 32'h0000_3000) begin errors++; $display("FAIL merge_addr: got %h want 00003000", mem_req_addr); end
    tick();
    send_beats(32'hD000_0000, 0, 8, 1'b0);
    checks++; if (repair_resolved !== 1'b1 || fill_addr !== 32'h0000_3000 || fill_data !== blk(32'hD000_0000)) begin
      errors++; $display("FAIL merge_resolve: res %0b addr %h want 1 00003000", repair_resolved, fill_addr); end
    tick(); tick(); tick();
    checks++; if (req_cnt - req0 !== 1 || res_cnt - res0 !== 1) begin
      errors++; $display("FAIL merge_counts: reqs %0d resolves %0d want 1 1", req_cnt - req0, res_cnt - res0); end
    // After a merge the write side must win the next tie
    read_repair_request = 1'b1;  missed_raddr = 32'h0000_0100;
    write_repair_request = 1'b1; missed_waddr = 32'h0000_2000;
    tick();
    checks++; if (write_repair_req_acq !== 1'b1 || read_repair_req_acq !== 1'b0) begin
      errors++; $display("FAIL merge_next_tie: rd %0b wr %0b want 0 1", read_repair_req_acq, write_repair_req_acq); end
    read_repair_request = 1'b0; write_repair_request = 1'b0;
    tick(); tick();
    send_beats(32'h1100_0000, 0, 8, 1'b0);
    checks++; if (repair_resolved !== 1'b1 || fill_addr !== 32'h0000_2000) begin
      errors++; $display("FAIL merge_next_resolve: res %0b addr %h want 1 00002000", repair_resolved, fill_addr); end
    tick();
    last_block = blk(32'h1100_0000);
  endtask

  task automatic test_backpressure();
    mem_resp_valid = 1'b1; mem_resp_data = {4{32'hDEAD_BEEF}};
    tick();
    checks++; if (busy !== 1'b0 || fill_data !== last_block) begin
      errors++; $display("FAIL bp_idle_stray: busy %0b data %h want 0 %h", busy, fill_data, last_block); end
    read_repair_request = 1'b1; missed_raddr = 32'h0000_4010;
    mem_req_ready = 1'b0;
    tick();
    read_repair_request = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_4000) begin
        errors++; $display("FAIL bp_hold_%0d: valid %0b addr %h want 1 00004000", k, mem_req_valid, mem_req_addr); end
      tick();
    end
    mem_req_ready = 1'b1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_4000) begin
      errors++; $display("FAIL bp_handshake: valid %0b addr %h want 1 00004000", mem_req_valid, mem_req_addr); end
    tick();
    mem_resp_valid = 1'b0;
    send_beats(32'h2200_0000, 0, 7, 1'b1);
    checks++; if (repair_resolved !== 1'b0) begin errors++; $display("FAIL bp_early_resolve: got %0b want 0", repair_resolved); end
    send_beats(32'h2200_0000, 7, 1, 1'b1);
    checks++; if (repair_resolved !== 1'b1 || fill_addr !== 32'h0000_4000 || fill_data !== blk(32'h2200_0000)) begin
      errors++; $display("FAIL bp_resolve: res %0b addr %h data %h want 1 00004000 %h", repair_resolved, fill_addr, fill_data, blk(32'h2200_0000)); end
    tick();
  endtask

  task automatic test_reset_mid_fill();
    int res0;
    read_repair_request = 1'b1; missed_raddr = 32'h0000_5000;
    tick();
    read_repair_request = 1'b0;
    tick(); tick();
    send_beats(32'h3300_0000, 0, 3, 1'b0);
    res0 = res_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || {read_repair_req_acq, write_repair_req_acq, repair_resolved, mem_req_valid} !== 4'b0) begin
      errors++; $display("FAIL rstfill_outputs: busy %0b strobes %b want 0", busy, {read_repair_req_acq, write_repair_req_acq, repair_resolved, mem_req_valid}); end
    checks++; if (fill_data !== '0 || fill_addr !== 32'd0 || fill_mask !== '0) begin
      errors++; $display("FAIL rstfill_data: data %h addr %h want 0", fill_data, fill_addr); end
    send_beats(32'h3300_0000, 3, 5, 1'b0);
    checks++; if (res_cnt !== res0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstfill_no_resolve: resolves %0d busy %0b want %0d 0", res_cnt, busy, res0); end
    read_repair_request = 1'b1; missed_raddr = 32'h0000_6000;
    tick();
    checks++; if (read_repair_req_acq !== 1'b1) begin errors++; $display("FAIL rstfill_restart_acq: got %0b want 1", read_repair_req_acq); end
    read_repair_request = 1'b0;
    tick(); tick();
    send_beats(32'hE000_0000, 0, 8, 1'b0);
    checks++; if (repair_resolved !== 1'b1 || fill_addr !== 32'h0000_6000 || fill_data !== blk(32'hE000_0000)) begin
      errors++; $display("FAIL rstfill_restart: res %0b addr %h data %h want 1 00006000 %h", repair_resolved, fill_addr, fill_data, blk(32'hE000_0000)); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    read_repair_request = 1'b0; write_repair_request = 1'b0;
    missed_raddr = '0; missed_waddr = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_merge();
    test_backpressure();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
